// File: rtl/fm_step3.sv
// fm_step3: sequential shift-add significand multiply with leading-one scan; ZERO_BYPASS_EN skips zero operands
module fm_step3 #(
  parameter int SIG_W = 11,
  parameter int EXP_W = 8,
  parameter int CNT_W = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SIG_W-1:0]   sig_a,
  input  logic [SIG_W-1:0]   sig_b,
  input  logic [EXP_W-1:0]   ex_in,
  input  logic               sign_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W-1:0]   ex_added,
  output logic               out_sign,
  output logic [2*SIG_W-1:0] mul_out,
  output logic [CNT_W-1:0]   count
);
  localparam int PW = 2 * SIG_W;
  localparam int IW = (SIG_W > 1) ? $clog2(SIG_W) : 1;
  typedef enum logic [1:0] {IDLE, MUL, LOD, DONE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] a_q, acc;
  logic [SIG_W-1:0] b_q;
  logic [IW-1:0] iter;
  logic accept, zero_op, last_iter, lod_hit;
  assign in_ready  = (state == IDLE) && !RESET;
  assign accept    = in_valid && in_ready;
  assign last_iter = (iter == IW'(SIG_W - 1));
  assign lod_hit   = acc[count] || (count == '0);
  assign out_valid = (state == DONE);
  assign mul_out   = acc;
`ifdef ZERO_BYPASS_EN
  assign zero_op = (sig_a == '0) || (sig_b == '0);
`else
  assign zero_op = 1'b0;
`endif
  // state register; reset aborts any operation in flight
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end
  // next-state: accept, SIG_W multiply steps, leading-one scan, hold until taken
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = zero_op ? DONE : MUL;
      MUL:     if (last_iter) state_nx = LOD;
      LOD:     if (lod_hit) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // datapath: operand capture, shift-add accumulate, count-down leading-one search
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      iter     <= '0;
      count    <= '0;
      ex_added <= '0;
      out_sign <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q      <= PW'(sig_a);
          b_q      <= sig_b;
          ex_added <= ex_in;
          out_sign <= sign_in;
          acc      <= '0;
          iter     <= '0;
          count    <= '0;
        end
        MUL: begin
          if (b_q[iter]) acc <= acc + (a_q << iter);
          iter <= iter + IW'(1);
          if (last_iter) count <= CNT_W'(PW - 1);
        end
        LOD: if (!lod_hit) count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fm_step3.sv
// tb_fm_step3: randomized self-checking bench for fm_step3 against an arithmetic reference model
module tb_fm_step3;
  localparam int SIG_W = 11;
  localparam int EXP_W = 8;
  localparam int CNT_W = 5;
  localparam int PW = 2 * SIG_W;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [SIG_W-1:0] sig_a = '0;
  logic [SIG_W-1:0] sig_b = '0;
  logic [EXP_W-1:0] ex_in = '0;
  logic sign_in = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [EXP_W-1:0] ex_added;
  logic out_sign;
  logic [PW-1:0] mul_out;
  logic [CNT_W-1:0] count;
  int errors = 0;
  int checks = 0;
`ifdef ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always #5 CLK = ~CLK;

  fm_step3 #(.SIG_W(SIG_W), .EXP_W(EXP_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .sig_a(sig_a), .sig_b(sig_b), .ex_in(ex_in), .sign_in(sign_in),
    .out_valid(out_valid), .out_ready(out_ready), .ex_added(ex_added),
    .out_sign(out_sign), .mul_out(mul_out), .count(count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lead_one(input logic [PW-1:0] p);
    int r;
    r = 0;
    for (int i = 0; i < PW; i++) if (p[i]) r = i;
    return r;
  endfunction

  function automatic int exp_latency(input logic [SIG_W-1:0] a, input logic [SIG_W-1:0] b);
    logic [PW-1:0] p;
    p = PW'(a) * PW'(b);
    if (p == '0) return BYPASS ? 0 : SIG_W + PW;
    return SIG_W + PW - lead_one(p);
  endfunction

  task automatic scramble_inputs();
    sig_a   = SIG_W'($urandom);
    sig_b   = SIG_W'($urandom);
    ex_in   = EXP_W'($urandom);
    sign_in = 1'($urandom);
  endtask

  task automatic run_op(input logic [SIG_W-1:0] a, input logic [SIG_W-1:0] b,
                        input logic [EXP_W-1:0] e, input logic s, input int hold);
    logic [PW-1:0] p;
    int n;
    p = PW'(a) * PW'(b);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    check("in_ready_idle", in_ready, 1);
    sig_a = a; sig_b = b; ex_in = e; sign_in = s; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    scramble_inputs();
    n = 0;
    while (!out_valid && n < 60) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      scramble_inputs();
      @(posedge CLK); #1;
      n++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("latency", n, exp_latency(a, b));
    check("mul_out", mul_out, p);
    check("count", count, lead_one(p));
    check("ex_added", ex_added, e);
    check("out_sign", out_sign, s);
    check("in_ready_busy", in_ready, 0);
    repeat (hold) begin
      in_valid = 1'b1;
      scramble_inputs();
      @(posedge CLK); #1;
      check("hold_valid", out_valid, 1);
      check("hold_mul", mul_out, p);
      check("hold_count", count, lead_one(p));
      check("hold_ex", ex_added, e);
      check("hold_sign", out_sign, s);
      check("hold_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    check("released", out_valid, 0);
    check("ready_after", in_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [SIG_W-1:0] a, b;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_mul", mul_out, 0);
    check("rst_count", count, 0);
    check("rst_ex", ex_added, 0);
    check("rst_sign", out_sign, 0);
    check("rst_ready", in_ready, 0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    #1;
    run_op(11'h600, 11'h600, 8'h80, 1'b1, 0);
    run_op(11'h400, 11'h400, 8'h7F, 1'b0, 0);
    run_op(11'h7FF, 11'h7FF, 8'h01, 1'b1, 0);
    run_op(11'h000, 11'h500, 8'h44, 1'b0, 0);
    run_op(11'h500, 11'h000, 8'h45, 1'b1, 1);
    run_op(11'h600, 11'h600, 8'h80, 1'b1, 5);
    sig_a = 11'h400; sig_b = 11'h400; ex_in = 8'h33; sign_in = 1'b1; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge CLK);
    #1 RESET = 1'b1;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_mul", mul_out, 0);
    check("abort_count", count, 0);
    check("abort_ex", ex_added, 0);
    check("abort_sign", out_sign, 0);
    check("abort_ready", in_ready, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    #1;
    check("abort_idle", in_ready, 1);
    check("abort_noresult", out_valid, 0);
    run_op(11'h400, 11'h400, 8'h7F, 1'b0, 0);
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 7))
        0:       a = '0;
        1:       a = '1;
        2:       a = SIG_W'(1) << $urandom_range(0, SIG_W - 1);
        default: a = SIG_W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = '1;
        2:       b = SIG_W'(1) << $urandom_range(0, SIG_W - 1);
        default: b = SIG_W'($urandom);
      endcase
      run_op(a, b, EXP_W'($urandom), 1'($urandom), $urandom_range(0, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
